// File: rtl/alu_pkg.sv
// Shared definitions for the alu issue stage: opcodes, FSM states, request layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic OP_FADD = 1'b0;   // IEEE-754 single-precision add
    localparam logic OP_IMUL = 1'b1;   // signed 32-bit multiply

    localparam int ALU_DATA_W = 32;
    localparam int ALU_TAG_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Request layout at the native alu widths.
    typedef struct packed {
        logic [ALU_DATA_W-1:0] x;
        logic [ALU_DATA_W-1:0] y;
        logic                  op;
        logic [ALU_TAG_W-1:0]  tag;
    } req_t;

    // Width of a down-counter that must hold lat-1 (at least one bit).
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Request buffer: DEPTH-entry FIFO, pointers carry an extra wrap bit.
// Latency: entry visible at pop_dat the edge after push; no bypass.
// Backpressure: full blocks push (even with a same-cycle pop); pop on empty ignored.
//
// Ports: clk/rst (async active-high), push/push_dat, pop/pop_dat (head, valid
// when !empty), full, empty.
module alu_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    // Same slot address but different lap: writer is a full lap ahead.
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage for the shared alu: queues requests, holds operands ALU_LAT cycles, returns result+tag.
// Latency: accept at E0, pop at E1, result captured at E(ALU_LAT+1); one request per ALU_LAT+1 cycles.
// Backpressure: in_ready = !full; response held stable until out_ready, no pop while waiting.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   in_*              request port (valid/ready): x, y, op, tag
//   alu_x/y/op        operands driven to alu, change only when a request is popped
//   alu_result/ovf    alu outputs, sampled at the end of the settle window
//   out_*             response port (valid/ready): result, overflow, tag
//   busy              queue non-empty or a request in flight
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int ALU_LAT = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    input  logic              in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_overflow,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_overflow,
    output logic [TAG_W-1:0]  out_tag,
    output logic              busy
);

    localparam int CNT_W = cnt_width(ALU_LAT);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

    // Queue entry at this instance's widths.
    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
        logic              op;
        logic [TAG_W-1:0]  tag;
    } slot_t;

    slot_t            push_dat;
    slot_t            head_dat;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             capture;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [TAG_W-1:0] cur_tag_q;

    // ------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    always_comb begin
        push_dat     = '0;
        push_dat.x   = in_x;
        push_dat.y   = in_y;
        push_dat.op  = in_op;
        push_dat.tag = in_tag;
    end

    alu_req_fifo #(
        .WIDTH ($bits(slot_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Consuming the response and issuing the next request share
                // one edge so back-to-back work costs ALU_LAT+1 cycles.
                if (out_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, counter and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_x        <= '0;
            alu_y        <= '0;
            alu_op       <= 1'b0;
            cnt_q        <= '0;
            cur_tag_q    <= '0;
            out_result   <= '0;
            out_overflow <= 1'b0;
            out_tag      <= '0;
        end else begin
            if (pop) begin
                alu_x     <= head_dat.x;
                alu_y     <= head_dat.y;
                alu_op    <= head_dat.op;
                cur_tag_q <= head_dat.tag;
                cnt_q     <= CNT_INIT;
            end else if (state_q == ISSUE && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (capture) begin
                out_result   <= alu_result;
                out_overflow <= alu_overflow;
                out_tag      <= cur_tag_q;
            end
        end
    end

    // A response is pending exactly while the FSM sits in DONE.
    assign out_valid = (state_q == DONE);
    assign busy      = !fifo_empty || (state_q != IDLE);

endmodule
